icache: RTL and testbench

//  Direct-mapped, one-word-per-line instruction cache between the instruction fetcher and
//  the memory controller's fetch port. A hit returns the instruction one cycle after the

---
 rtl/icache_pkg.sv | 13 +
 rtl/icache.sv | 132 +++++++++++++
 tb/tb_icache.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths and FSM state type for the instruction cache
package icache_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int ICACHE_INDEX_BITS = 6;
    localparam int ICACHE_TAG_BITS   = 30 - ICACHE_INDEX_BITS;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_MISS_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache with flush-safe miss handling
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  in_fetch_ena,
    input  logic [31:0]           in_fetch_addr,
    input  logic                  in_flush,
    output logic                  out_fetch_ok,
    output logic [DATA_WIDTH-1:0] out_fetch_inst,
    output logic                  out_mem_ena,
    output logic [31:0]           out_mem_addr,
    input  logic                  in_mem_ok,
    input  logic [DATA_WIDTH-1:0] in_mem_data
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES];

    state_e                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic                  drop_q, drop_d;
    logic [29:0]           req_word_q, req_word_d;
    logic                  fetch_ok_q, fetch_ok_d;
    logic [DATA_WIDTH-1:0] fetch_inst_q, fetch_inst_d;
    logic                  mem_ena_q, mem_ena_d;
    logic [29:0]           mem_word_q, mem_word_d;

    logic [INDEX_BITS-1:0] lookup_idx, fill_idx;
    logic [TAG_BITS-1:0]   lookup_tag, fill_tag;
    logic                  hit;
    logic                  fill_en;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^in_fetch_addr[1:0];

    assign lookup_idx = in_fetch_addr[INDEX_BITS+1:2];
    assign lookup_tag = in_fetch_addr[31:INDEX_BITS+2];
    assign fill_idx   = req_word_q[INDEX_BITS-1:0];
    assign fill_tag   = req_word_q[29:INDEX_BITS];
    assign hit        = valid_q[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        drop_d       = drop_q;
        req_word_d   = req_word_q;
        fetch_ok_d   = 1'b0;
        fetch_inst_d = fetch_inst_q;
        mem_ena_d    = 1'b0;
        mem_word_d   = mem_word_q;
        fill_en      = 1'b0;
        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    // The cycle showing ok is the handshake cycle; the fetcher's request is
                    // still the completed one, so it must not be looked up again.
                    if (in_fetch_ena && !in_flush && !fetch_ok_q) begin
                        if (hit) begin
                            fetch_ok_d   = 1'b1;
                            fetch_inst_d = data_mem[lookup_idx];
                        end else begin
                            mem_ena_d  = 1'b1;
                            mem_word_d = in_fetch_addr[31:2];
                            req_word_d = in_fetch_addr[31:2];
                            drop_d     = 1'b0;
                            state_d    = ST_MISS_WAIT;
                        end
                    end
                end
                ST_MISS_WAIT: begin
                    if (in_mem_ok) begin
                        fill_en            = 1'b1;
                        valid_d[fill_idx]  = 1'b1;
                        if (!drop_q && !in_flush) begin
                            fetch_ok_d   = 1'b1;
                            fetch_inst_d = in_mem_data;
                        end
                        drop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (in_flush) begin
                        drop_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            drop_q       <= 1'b0;
            req_word_q   <= '0;
            fetch_ok_q   <= 1'b0;
            fetch_inst_q <= '0;
            mem_ena_q    <= 1'b0;
            mem_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            drop_q       <= drop_d;
            req_word_q   <= req_word_d;
            fetch_ok_q   <= fetch_ok_d;
            fetch_inst_q <= fetch_inst_d;
            mem_ena_q    <= mem_ena_d;
            mem_word_q   <= mem_word_d;
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= in_mem_data;
        end
    end

    assign out_fetch_ok   = fetch_ok_q;
    assign out_fetch_inst = fetch_inst_q;
    assign out_mem_ena    = mem_ena_q;
    assign out_mem_addr   = {mem_word_q, 2'b00};

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        in_fetch_ena = 1'b0;
    logic [31:0] in_fetch_addr = '0;
    logic        in_flush = 1'b0;
    logic        out_fetch_ok;
    logic [31:0] out_fetch_inst;
    logic        out_mem_ena;
    logic [31:0] out_mem_addr;
    logic        in_mem_ok = 1'b0;
    logic [31:0] in_mem_data = '0;

    int total  = 0;
    int passed = 0;
    int mem_reqs = 0;
    int base_reqs;

    icache dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .in_fetch_ena   (in_fetch_ena),
        .in_fetch_addr  (in_fetch_addr),
        .in_flush       (in_flush),
        .out_fetch_ok   (out_fetch_ok),
        .out_fetch_inst (out_fetch_inst),
        .out_mem_ena    (out_mem_ena),
        .out_mem_addr   (out_mem_addr),
        .in_mem_ok      (in_mem_ok),
        .in_mem_data    (in_mem_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_mem_ena) mem_reqs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic request(input logic [31:0] addr);
        in_fetch_ena  = 1'b1;
        in_fetch_addr = addr;
    endtask

    task automatic reply(input logic [31:0] data);
        in_mem_ok   = 1'b1;
        in_mem_data = data;
    endtask

    task automatic idle_inputs();
        in_fetch_ena = 1'b0;
        in_mem_ok    = 1'b0;
        in_flush     = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("reset_ok",       {31'd0, out_fetch_ok}, 32'd0);
        check("reset_mem_ena",  {31'd0, out_mem_ena},  32'd0);
        check("reset_inst",     out_fetch_inst,        32'd0);
        check("reset_mem_addr", out_mem_addr,          32'd0);
        rst = 1'b0;

        // 1 cold miss
        request(32'h0000_1004);
        tick();
        check("t1_mem_ena",  {31'd0, out_mem_ena},  32'd1);
        check("t1_mem_addr", out_mem_addr,          32'h0000_1004);
        check("t1_no_ok",    {31'd0, out_fetch_ok}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_wait_no_ok",  {31'd0, out_fetch_ok}, 32'd0);
            check("t1_single_req",  {31'd0, out_mem_ena},  32'd0);
        end
        reply(32'hDEAD_BEEF);
        tick();
        check("t1_fill_ok",   {31'd0, out_fetch_ok}, 32'd1);
        check("t1_fill_inst", out_fetch_inst,        32'hDEAD_BEEF);
        idle_inputs();
        tick();

        // 2 hit after fill, request held one extra cycle
        base_reqs = mem_reqs;
        request(32'h0000_1004);
        tick();
        check("t2_hit_ok",   {31'd0, out_fetch_ok}, 32'd1);
        check("t2_hit_inst", out_fetch_inst,        32'hDEAD_BEEF);
        check("t2_no_mem",   {31'd0, out_mem_ena},  32'd0);
        tick();
        check("t2_no_double_ok", {31'd0, out_fetch_ok}, 32'd0);
        idle_inputs();
        tick();
        check("t2_mem_reqs", mem_reqs - base_reqs, 32'd0);

        // 3 conflict on index 1
        base_reqs = mem_reqs;
        request(32'h0000_1104);
        tick();
        check("t3a_mem_ena",  {31'd0, out_mem_ena}, 32'd1);
        check("t3a_mem_addr", out_mem_addr,         32'h0000_1104);
        reply(32'hCAFE_0001);
        tick();
        check("t3a_ok",   {31'd0, out_fetch_ok}, 32'd1);
        check("t3a_inst", out_fetch_inst,        32'hCAFE_0001);
        idle_inputs();
        tick();
        request(32'h0000_1004);
        tick();
        check("t3b_mem_ena",  {31'd0, out_mem_ena},  32'd1);
        check("t3b_mem_addr", out_mem_addr,          32'h0000_1004);
        check("t3b_no_ok",    {31'd0, out_fetch_ok}, 32'd0);
        reply(32'hDEAD_BEEF);
        tick();
        check("t3b_ok",   {31'd0, out_fetch_ok}, 32'd1);
        check("t3b_inst", out_fetch_inst,        32'hDEAD_BEEF);
        idle_inputs();
        tick();
        check("t3_mem_reqs", mem_reqs - base_reqs, 32'd2);

        // 4 flush mid-miss
        request(32'h0000_2000);
        tick();
        check("t4_mem_ena", {31'd0, out_mem_ena}, 32'd1);
        tick();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        in_fetch_ena = 1'b0;
        tick();
        tick();
        reply(32'h1234_5678);
        tick();
        check("t4_dropped_ok", {31'd0, out_fetch_ok}, 32'd0);
        idle_inputs();
        tick();
        base_reqs = mem_reqs;
        request(32'h0000_2000);
        tick();
        check("t4_hit_ok",   {31'd0, out_fetch_ok}, 32'd1);
        check("t4_hit_inst", out_fetch_inst,        32'h1234_5678);
        idle_inputs();
        tick();
        check("t4_mem_reqs", mem_reqs - base_reqs, 32'd0);

        // flush and reply together, then flush in IDLE
        request(32'h0000_3000);
        tick();
        check("t4b_mem_ena", {31'd0, out_mem_ena}, 32'd1);
        reply(32'hAAAA_5555);
        in_flush = 1'b1;
        tick();
        check("t4b_ok_suppressed", {31'd0, out_fetch_ok}, 32'd0);
        idle_inputs();
        request(32'h0000_3000);
        tick();
        check("t4b_hit_ok",   {31'd0, out_fetch_ok}, 32'd1);
        check("t4b_hit_inst", out_fetch_inst,        32'hAAAA_5555);
        idle_inputs();
        tick();
        request(32'h0000_4000);
        in_flush = 1'b1;
        tick();
        check("t4c_idle_flush_ok",  {31'd0, out_fetch_ok}, 32'd0);
        check("t4c_idle_flush_mem", {31'd0, out_mem_ena},  32'd0);
        idle_inputs();
        tick();

        // 5 ena low during a hit
        ena = 1'b0;
        request(32'h0000_1004);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_frozen_ok",  {31'd0, out_fetch_ok}, 32'd0);
            check("t5_frozen_mem", {31'd0, out_mem_ena},  32'd0);
        end
        ena = 1'b1;
        tick();
        check("t5_ok",   {31'd0, out_fetch_ok}, 32'd1);
        check("t5_inst", out_fetch_inst,        32'hDEAD_BEEF);
        idle_inputs();
        tick();

        // 6 async reset mid-miss
        request(32'h0000_5000);
        tick();
        check("t6_mem_ena_before", {31'd0, out_mem_ena}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_mem_ena",  {31'd0, out_mem_ena}, 32'd0);
        check("t6_async_mem_addr", out_mem_addr,         32'd0);
        check("t6_async_inst",     out_fetch_inst,       32'd0);
        idle_inputs();
        tick();
        rst = 1'b0;
        reply(32'h0000_0099);
        tick();
        check("t6_stray_ok",  {31'd0, out_fetch_ok}, 32'd0);
        check("t6_stray_mem", {31'd0, out_mem_ena},  32'd0);
        idle_inputs();
        tick();
        request(32'h0000_2000);
        tick();
        check("t6_cold_mem_ena",  {31'd0, out_mem_ena},  32'd1);
        check("t6_cold_mem_addr", out_mem_addr,          32'h0000_2000);
        check("t6_cold_no_ok",    {31'd0, out_fetch_ok}, 32'd0);
        reply(32'h0BAD_F00D);
        tick();
        check("t6_refill_inst", out_fetch_inst, 32'h0BAD_F00D);
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
